// File: rtl/gameconsole_pkg.sv
// Shared types and defaults for the game console video subsystem.
package gameconsole_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   localparam int VRAM_ARB_MAX_BURST = 16;

endpackage

// File: rtl/vram_arb.sv
// Two-port VRAM arbiter: CPU and DMA share the VRAM host port, round-robin with a DMA burst lock.
// Read data is steered back to the requester that issued the read, one cycle later.
module vram_arb
   import gameconsole_pkg::*;
#(
   parameter int MAX_BURST = VRAM_ARB_MAX_BURST
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,

   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_lock,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,

   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

   owner_e     last_owner_q, last_owner_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   logic       rd_pend_q, rd_pend_d;
   owner_e     rd_owner_q, rd_owner_d;
   logic       lock_win;
   logic       pick_dma;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      pick_dma = 1'b0;
      lock_win = (last_owner_q == OWN_DMA) && dma_lock && (burst_cnt_q < BURST_LIM);
      if (cpu_req && dma_req) begin
         pick_dma = lock_win || (last_owner_q == OWN_CPU);
      end else begin
         pick_dma = dma_req;
      end
      // Grants are gated by rst_n so the port is quiet for the whole reset window.
      cpu_gnt = rst_n && cpu_req && !pick_dma;
      dma_gnt = rst_n && dma_req && pick_dma;
   end

   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (cpu_gnt) begin
         mem_en   = 1'b1;
         mem_we   = cpu_we;
         mem_addr = cpu_addr;
         mem_din  = cpu_wdata;
      end else if (dma_gnt) begin
         mem_en   = 1'b1;
         mem_we   = dma_we;
         mem_addr = dma_addr;
         mem_din  = dma_wdata;
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      rd_pend_d    = (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
      rd_owner_d   = dma_gnt ? OWN_DMA : OWN_CPU;

      if (cpu_gnt) begin
         last_owner_d = OWN_CPU;
      end else if (dma_gnt) begin
         last_owner_d = OWN_DMA;
      end

      if (cpu_gnt || !dma_lock) begin
         burst_cnt_d = '0;
      end else if (dma_gnt && (burst_cnt_q < BURST_LIM)) begin
         burst_cnt_d = burst_cnt_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner_q <= OWN_DMA;
         burst_cnt_q  <= '0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= OWN_CPU;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign cpu_rvalid = rd_pend_q && (rd_owner_q == OWN_CPU);
   assign dma_rvalid = rd_pend_q && (rd_owner_q == OWN_DMA);
   assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
   assign dma_rdata  = dma_rvalid ? mem_dout : '0;

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter MAX_BURST, default 16, SHALL set the maximum consecutive DMA grants while CPU requests under lock (range 1..255).
REQ-002 clk  input  1  system clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  CPU access request, held until granted.
REQ-005 cpu_we / cpu_addr / cpu_wdata  input  1/32/32  CPU write-enable, byte address, write data.
REQ-006 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-007 cpu_rvalid / cpu_rdata  output  1/32  CPU read response.
REQ-008 dma_req / dma_we / dma_addr / dma_wdata  input  1/1/32/32  DMA requester, same semantics as CPU.
REQ-009 dma_lock  input  1  DMA requests burst priority.
REQ-010 dma_gnt / dma_rvalid / dma_rdata  output  1/1/32  DMA grant and read response.
REQ-011 mem_en / mem_we / mem_addr / mem_din  output  1/1/32/32  VRAM host port command.
REQ-012 mem_dout  input  32  VRAM read data, valid one cycle after a read command.

Function
REQ-013 Grant SHALL be combinational from current req and registered arbiter state; at most one of cpu_gnt/dma_gnt high per cycle.
REQ-014 On any grant, mem_en=1 and mem_we/mem_addr/mem_din SHALL equal the granted requester's inputs in the same cycle; no grant -> mem_en=0, other mem_* outputs 0.
REQ-015 Arbitration: single requester SHALL be granted immediately; both requesting -> round-robin, requester not granted last SHALL win, unless lock rule (REQ-016) applies.
REQ-016 Lock: if last grant was DMA, dma_lock=1, dma_req=1 and burst_cnt<MAX_BURST, DMA SHALL win over CPU.
REQ-017 burst_cnt (8 bit) SHALL increment on each DMA grant while dma_lock=1, clear on any CPU grant or when dma_lock=0; saturates at MAX_BURST.
REQ-018 At burst_cnt==MAX_BURST with CPU requesting, CPU SHALL be granted next cycle; burst_cnt then clears.
REQ-019 last_owner register SHALL update only on grant cycles; idle cycles SHALL not change it.
REQ-020 Read response: a granted read (we=0) SHALL register owner tag; next cycle the owner's rvalid=1 and rdata=mem_dout; other rdata 0.
REQ-021 Writes SHALL produce no rvalid; back-to-back reads from alternating owners SHALL each return in order with fixed 1-cycle latency.
REQ-022 rvalid SHALL be a single-cycle pulse per read; no outstanding-request limit beyond one-per-cycle.

Reset
REQ-023 While rst_n=0: cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en = 0; rdata outputs 0; burst_cnt=0; last_owner=DMA (CPU wins first contention).
REQ-024 Reset asserted mid-read SHALL drop the pending rvalid; no response after deassertion.
REQ-025 First cycle after rst_n rises SHALL arbitrate normally.

Structure
REQ-026 Owner enum (OWN_CPU, OWN_DMA) and VRAM_ARB_MAX_BURST default SHALL live in gameconsole_pkg.
REQ-027 Single module, no sub-modules; instantiated between the system bus and vram host port inside vpu.

Verification
REQ-028 CPU alone reads 0x0000_0100 -> cpu_gnt same cycle, mem_addr=0x100, cpu_rvalid next cycle with rdata=mem_dout.
REQ-029 Both request continuously, dma_lock=0 -> grants alternate CPU,DMA,CPU,DMA from reset.
REQ-030 dma_lock=1, MAX_BURST=4, both requesting, DMA granted last -> 4 DMA grants, 1 CPU grant, repeat.
REQ-031 Alternating CPU read 0x10 / DMA read 0x20 -> cpu_rvalid, dma_rvalid pulses in order with matching data, never overlapping.
REQ-032 DMA write 0xDEADBEEF to 0x40 -> mem_we=1, mem_din=0xDEADBEEF, no rvalid.
REQ-033 rst_n low one cycle after read grant -> no rvalid; all outputs 0 during reset.
